posit_quire_accumulator: RTL and testbench

- Sequential dot-product accumulator sitting directly downstream of the posit-to-quire expansion stage.
- Consumes a stream of expanded terms, each with sign, biased exponent, fraction and inf/zero flags, and accumulates them into a wide two's-complement fixed-point quire.
- A term flagged last closes a dot product: the result is presented on a valid/ready output, and the accumulator restarts from zero without a bubble.

---
 rtl/posit_quire_accumulator_if.sv | 48 ++++
 rtl/posit_quire_accumulator.sv | 177 +++++++++++++++++
 tb/tb_posit_quire_accumulator.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/posit_quire_accumulator_if.sv
// ---------------------------------------------------------------------------
// posit_quire_accumulator_if
// Term-input and result-output handshake bundle for posit_quire_accumulator.
//   clear                 : synchronous abort of the dot product in progress
//   inValid / inReady     : term handshake
//   inIsInf, inIsZero     : term is NaR/inf, term is zero
//   inSign, inExp, inFrac : sign, left-shift amount, unsigned expanded fraction
//   inLast                : term closes the current dot product
//   outValid / outReady   : result handshake
//   outQuire              : signed accumulated quire (ACC_BITS wide)
//   outIsInf, outOverflow : sticky inf / signed-overflow flags of the result
//   outCount              : number of terms in the result (saturating)
// master = term producer / result consumer, slave = accumulator.
// ---------------------------------------------------------------------------
interface posit_quire_accumulator_if #(
    parameter int EXP_BITS   = 5,
    parameter int FRAC_BITS  = 10,
    parameter int CARRY_BITS = 8,
    parameter int COUNT_BITS = 16
);
    localparam int ACC_BITS = 1 + CARRY_BITS + FRAC_BITS + (1 << EXP_BITS) - 1;

    logic                        clear;
    logic                        inValid;
    logic                        inReady;
    logic                        inIsInf;
    logic                        inIsZero;
    logic                        inSign;
    logic [EXP_BITS-1:0]         inExp;
    logic [FRAC_BITS-1:0]        inFrac;
    logic                        inLast;
    logic                        outValid;
    logic                        outReady;
    logic signed [ACC_BITS-1:0]  outQuire;
    logic                        outIsInf;
    logic                        outOverflow;
    logic [COUNT_BITS-1:0]       outCount;

    modport master (
        output clear, inValid, inIsInf, inIsZero, inSign, inExp, inFrac, inLast, outReady,
        input  inReady, outValid, outQuire, outIsInf, outOverflow, outCount
    );

    modport slave (
        input  clear, inValid, inIsInf, inIsZero, inSign, inExp, inFrac, inLast, outReady,
        output inReady, outValid, outQuire, outIsInf, outOverflow, outCount
    );
endinterface

// File: rtl/posit_quire_accumulator.sv
// ---------------------------------------------------------------------------
// posit_quire_accumulator
// Two-stage dot-product accumulator fed by the posit-to-quire expansion stage.
// Stage 1 aligns each expanded term into a two's-complement quire word,
// stage 2 adds it into the running quire. A term flagged last moves the
// post-add result into the output register and restarts the accumulator
// from zero in the same cycle, so consecutive dot products need no bubble.
//
// Ports:
//   clock  : rising-edge clock
//   resetN : asynchronous active-low reset, clears every register
//   bus    : posit_quire_accumulator_if.slave (term in, result out, clear)
//
// Build option:
//   QUIRE_SATURATE_EN defined   : the first overflow clamps the quire to the
//                                 signed extreme matching the addends and
//                                 holds it until the dot product closes.
//   QUIRE_SATURATE_EN undefined : the quire wraps modulo 2^ACC_BITS.
//   outOverflow is sticky in both builds.
// ---------------------------------------------------------------------------
module posit_quire_accumulator #(
    parameter int EXP_BITS   = 5,
    parameter int FRAC_BITS  = 10,
    parameter int CARRY_BITS = 8,
    parameter int COUNT_BITS = 16
) (
    input logic                      clock,
    input logic                      resetN,
    posit_quire_accumulator_if.slave bus
);
    localparam int ACC_BITS = 1 + CARRY_BITS + FRAC_BITS + (1 << EXP_BITS) - 1;

    function automatic logic [COUNT_BITS-1:0] sat_inc(input logic [COUNT_BITS-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    logic                        r_s1Valid;
    logic signed [ACC_BITS-1:0]  r_s1Term;
    logic                        r_s1Inf;
    logic                        r_s1Last;

    logic signed [ACC_BITS-1:0]  r_acc;
    logic                        r_inf;
    logic                        r_ovf;
    logic [COUNT_BITS-1:0]       r_cnt;

    logic                        r_outValid;
    logic signed [ACC_BITS-1:0]  r_outQuire;
    logic                        r_outInf;
    logic                        r_outOvf;
    logic [COUNT_BITS-1:0]       r_outCnt;

    logic [ACC_BITS-1:0]         w_mag;
    logic signed [ACC_BITS-1:0]  w_term;
    logic                        w_outFree;
    logic                        w_s1Advance;
    logic                        w_inReady;
    logic                        w_close;
    logic signed [ACC_BITS-1:0]  w_sum;
    logic                        w_addOvf;
    logic signed [ACC_BITS-1:0]  w_accNext;
    logic                        w_infNext;
    logic                        w_ovfNext;
    logic [COUNT_BITS-1:0]       w_cntNext;

    // A pending last term may only advance once the output register can
    // take its result; non-last terms never wait on the consumer.
    assign w_outFree   = !r_outValid || bus.outReady;
    assign w_s1Advance = r_s1Valid && (!r_s1Last || w_outFree);
    assign w_inReady   = bus.clear || !r_s1Valid || w_s1Advance;
    assign w_close     = w_s1Advance && r_s1Last && !bus.clear;

    assign bus.inReady     = w_inReady;
    assign bus.outValid    = r_outValid;
    assign bus.outQuire    = r_outQuire;
    assign bus.outIsInf    = r_outInf;
    assign bus.outOverflow = r_outOvf;
    assign bus.outCount    = r_outCnt;

    assign w_mag = ACC_BITS'(bus.inFrac) << bus.inExp;

    always_comb begin
        w_term = '0;
        if (!(bus.inIsZero || bus.inIsInf)) begin
            w_term = bus.inSign ? -$signed(w_mag) : $signed(w_mag);
        end
    end

    assign w_sum    = r_acc + r_s1Term;
    assign w_addOvf = (r_acc[ACC_BITS-1] == r_s1Term[ACC_BITS-1]) &&
                      (w_sum[ACC_BITS-1] != r_acc[ACC_BITS-1]);

`ifdef QUIRE_SATURATE_EN
    // Once overflowed the quire is already clamped; further terms are ignored.
    function automatic logic signed [ACC_BITS-1:0] sat_add(
        input logic signed [ACC_BITS-1:0] acc,
        input logic signed [ACC_BITS-1:0] sum,
        input logic                       ovf,
        input logic                       held
    );
        if (held) begin
            return acc;
        end else if (ovf) begin
            return acc[ACC_BITS-1] ? $signed({1'b1, {(ACC_BITS-1){1'b0}}})
                                   : $signed({1'b0, {(ACC_BITS-1){1'b1}}});
        end else begin
            return sum;
        end
    endfunction

    assign w_accNext = sat_add(r_acc, w_sum, w_addOvf, r_ovf);
`else
    assign w_accNext = w_sum;
`endif

    assign w_infNext = r_inf | r_s1Inf;
    assign w_ovfNext = r_ovf | w_addOvf;
    assign w_cntNext = sat_inc(r_cnt);

    // Stage 1: align term
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_s1Valid <= 1'b0;
            r_s1Term  <= '0;
            r_s1Inf   <= 1'b0;
            r_s1Last  <= 1'b0;
        end else if (bus.clear) begin
            r_s1Valid <= 1'b0;
        end else if (w_inReady) begin
            r_s1Valid <= bus.inValid;
            if (bus.inValid) begin
                r_s1Term <= w_term;
                r_s1Inf  <= bus.inIsInf;
                r_s1Last <= bus.inLast;
            end
        end
    end

    // Stage 2: accumulate
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_acc <= '0;
            r_inf <= 1'b0;
            r_ovf <= 1'b0;
            r_cnt <= '0;
        end else if (bus.clear || (w_s1Advance && r_s1Last)) begin
            r_acc <= '0;
            r_inf <= 1'b0;
            r_ovf <= 1'b0;
            r_cnt <= '0;
        end else if (w_s1Advance) begin
            r_acc <= w_accNext;
            r_inf <= w_infNext;
            r_ovf <= w_ovfNext;
            r_cnt <= w_cntNext;
        end
    end

    // Output register: loads the post-add values of a closing term
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_outValid <= 1'b0;
            r_outQuire <= '0;
            r_outInf   <= 1'b0;
            r_outOvf   <= 1'b0;
            r_outCnt   <= '0;
        end else if (w_close) begin
            r_outValid <= 1'b1;
            r_outQuire <= w_accNext;
            r_outInf   <= w_infNext;
            r_outOvf   <= w_ovfNext;
            r_outCnt   <= w_cntNext;
        end else if (bus.outReady) begin
            r_outValid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_posit_quire_accumulator.sv
module tb_posit_quire_accumulator;
    localparam int EXP_BITS   = 5;
    localparam int FRAC_BITS  = 10;
    localparam int CARRY_BITS = 8;
    localparam int COUNT_BITS = 16;
    localparam int ACC_BITS   = 1 + CARRY_BITS + FRAC_BITS + (1 << EXP_BITS) - 1;
    localparam longint MODQ   = longint'(1) << ACC_BITS;
    localparam longint MAXQ   = (longint'(1) << (ACC_BITS - 1)) - 1;
    localparam longint MINQ   = -(longint'(1) << (ACC_BITS - 1));

    logic clock  = 1'b0;
    logic resetN = 1'b0;

    posit_quire_accumulator_if #(
        .EXP_BITS(EXP_BITS), .FRAC_BITS(FRAC_BITS),
        .CARRY_BITS(CARRY_BITS), .COUNT_BITS(COUNT_BITS)
    ) bus ();

    posit_quire_accumulator #(
        .EXP_BITS(EXP_BITS), .FRAC_BITS(FRAC_BITS),
        .CARRY_BITS(CARRY_BITS), .COUNT_BITS(COUNT_BITS)
    ) dut (
        .clock (clock),
        .resetN(resetN),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        longint quire;
        bit     inf;
        bit     ovf;
        int     cnt;
    } res_t;

    res_t exp_q[$];

    // Reference model: exact integer value of each term, quire kept in range
    longint m_acc;
    bit     m_inf;
    bit     m_ovf;
    int     m_cnt;

    task automatic model_reset();
        m_acc = 0;
        m_inf = 0;
        m_ovf = 0;
        m_cnt = 0;
    endtask

    task automatic model_term(input bit s, input int e, input int f, input bit z,
                              input bit inf, input bit last);
        longint t;
        longint sum;
        bit     o;
        t = (z || inf) ? 0 : (longint'(f) << e);
        if (s) t = -t;
        sum = m_acc + t;
        o = (sum > MAXQ) || (sum < MINQ);
`ifdef QUIRE_SATURATE_EN
        if (!m_ovf) m_acc = o ? ((sum > MAXQ) ? MAXQ : MINQ) : sum;
`else
        if (sum > MAXQ) sum = sum - MODQ;
        else if (sum < MINQ) sum = sum + MODQ;
        m_acc = sum;
`endif
        m_ovf = m_ovf | o;
        m_inf = m_inf | inf;
        if (m_cnt < (1 << COUNT_BITS) - 1) m_cnt++;
        if (last) begin
            exp_q.push_back('{m_acc, m_inf, m_ovf, m_cnt});
            model_reset();
        end
    endtask

    // Present one term; returns one time unit after the accepting edge.
    task automatic send(input bit s, input int e, input int f, input bit z,
                        input bit inf, input bit last, input bit use_model);
        int n;
        bus.inValid  = 1'b1;
        bus.inSign   = s;
        bus.inExp    = EXP_BITS'(e);
        bus.inFrac   = FRAC_BITS'(f);
        bus.inIsZero = z;
        bus.inIsInf  = inf;
        bus.inLast   = last;
        n = 0;
        @(negedge clock);
        while (!bus.inReady && n < 200) begin
            n++;
            @(negedge clock);
        end
        if (!bus.inReady) begin
            chk("in_ready_timeout", 0, 1);
            @(posedge clock);
            #1;
            bus.inValid = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        bus.inValid = 1'b0;
        if (use_model) model_term(s, e, f, z, inf, last);
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.outReady = 1'b1;
        while ((exp_q.size() != 0 || bus.outValid) && n < 100) begin
            @(posedge clock);
            #1;
            bus.outReady = 1'b1;
            n++;
        end
        chk("drain_results_left", exp_q.size(), 0);
    endtask

    // Result monitor: every handshake is compared with the oldest expectation
    initial begin : monitor
        res_t e;
        forever begin
            @(negedge clock);
            if (resetN && bus.outValid && bus.outReady) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("res_quire", $signed(bus.outQuire), e.quire);
                    chk("res_inf", longint'(bus.outIsInf), longint'(e.inf));
                    chk("res_ovf", longint'(bus.outOverflow), longint'(e.ovf));
                    chk("res_cnt", longint'(bus.outCount), longint'(e.cnt));
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        chk("global_timeout", 1, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    typedef struct {
        bit     s;
        int     e;
        int     f;
        bit     z;
        bit     inf;
        bit     last;
        longint eq;
        bit     einf;
        bit     eovf;
        int     ecnt;
    } vec_t;

    vec_t tbl[9];
    bit   rnd_on;

    initial begin : stim
        int     c0;
        int     len;
        longint ovf_exp;

        tbl[0] = '{0, 3, 256, 0, 0, 0, 0, 0, 0, 0};
        tbl[1] = '{1, 1, 256, 0, 0, 1, 1536, 0, 0, 2};
        tbl[2] = '{0, 4, 55, 1, 0, 1, 0, 0, 0, 1};
        tbl[3] = '{0, 0, 5, 0, 0, 0, 0, 0, 0, 0};
        tbl[4] = '{0, 2, 7, 0, 1, 0, 0, 0, 0, 0};
        tbl[5] = '{0, 2, 3, 0, 0, 1, 17, 1, 0, 3};
        tbl[6] = '{1, 31, 1023, 0, 0, 1, -(longint'(1023) << 31), 0, 0, 1};
        tbl[7] = '{1, 4, 3, 0, 0, 0, 0, 0, 0, 0};
        tbl[8] = '{0, 0, 1, 0, 0, 1, -47, 0, 0, 2};

        bus.clear    = 1'b0;
        bus.inValid  = 1'b0;
        bus.inIsInf  = 1'b0;
        bus.inIsZero = 1'b0;
        bus.inSign   = 1'b0;
        bus.inExp    = '0;
        bus.inFrac   = '0;
        bus.inLast   = 1'b0;
        bus.outReady = 1'b0;
        model_reset();

        // Reset state
        #12;
        chk("rst_out_valid", bus.outValid, 0);
        chk("rst_quire", $signed(bus.outQuire), 0);
        chk("rst_inf", bus.outIsInf, 0);
        chk("rst_ovf", bus.outOverflow, 0);
        chk("rst_cnt", bus.outCount, 0);
        @(posedge clock);
        #1;
        resetN = 1'b1;
        @(negedge clock);
        chk("rst_in_ready", bus.inReady, 1);
        @(posedge clock);
        #1;

        // Single term: result appears on the second edge counting acceptance
        bus.outReady = 1'b1;
        exp_q.push_back('{256, 0, 0, 1});
        send(0, 0, 256, 0, 0, 1, 0);
        chk("lat_after_accept_edge", bus.outValid, 0);
        @(posedge clock);
        #1;
        chk("lat_after_next_edge", bus.outValid, 1);
        drain();

        // Table-driven dot products streamed back-to-back
        c0 = cyc;
        for (int i = 0; i < 9; i++) begin
            if (tbl[i].last) exp_q.push_back('{tbl[i].eq, tbl[i].einf, tbl[i].eovf, tbl[i].ecnt});
            send(tbl[i].s, tbl[i].e, tbl[i].f, tbl[i].z, tbl[i].inf, tbl[i].last, 0);
        end
        chk("table_no_stall_cycles", cyc - c0, 9);
        drain();

        // Output stall: two 2-term dot products with the consumer not ready
        bus.outReady = 1'b0;
        exp_q.push_back('{3, 0, 0, 2});
        exp_q.push_back('{-4, 0, 0, 2});
        send(0, 0, 1, 0, 0, 0, 0);
        send(0, 0, 2, 0, 0, 1, 0);
        send(0, 0, 4, 0, 0, 0, 0);
        send(1, 0, 8, 0, 0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("stall_in_ready", bus.inReady, 0);
            chk("stall_out_valid", bus.outValid, 1);
            chk("stall_quire_stable", $signed(bus.outQuire), 3);
            chk("stall_cnt_stable", bus.outCount, 2);
            @(posedge clock);
            #1;
        end
        bus.outReady = 1'b1;
        @(posedge clock);
        #1;
        chk("stall_second_result_valid", bus.outValid, 1);
        chk("stall_second_result_quire", $signed(bus.outQuire), -4);
        drain();

        // Overflow: 300 maximal positive terms
`ifdef QUIRE_SATURATE_EN
        ovf_exp = MAXQ;
`else
        ovf_exp = (longint'(300 * 1023) << 31) - MODQ;
`endif
        exp_q.push_back('{ovf_exp, 0, 1, 300});
        for (int i = 0; i < 300; i++) send(0, 31, 1023, 0, 0, (i == 299), 0);
        drain();

        // Clear after two terms; a term offered during clear is dropped
        send(0, 0, 1, 0, 0, 0, 0);
        send(0, 0, 2, 0, 0, 0, 0);
        bus.clear   = 1'b1;
        bus.inValid = 1'b1;
        bus.inFrac  = FRAC_BITS'(100);
        bus.inExp   = '0;
        bus.inSign  = 1'b0;
        bus.inLast  = 1'b1;
        @(negedge clock);
        chk("clear_in_ready", bus.inReady, 1);
        @(posedge clock);
        #1;
        bus.clear   = 1'b0;
        bus.inValid = 1'b0;
        exp_q.push_back('{12, 0, 0, 2});
        send(0, 0, 4, 0, 0, 0, 0);
        send(0, 0, 8, 0, 0, 1, 0);
        drain();

        // Asynchronous reset with a result pending
        bus.outReady = 1'b0;
        send(0, 0, 5, 0, 0, 0, 0);
        send(0, 0, 6, 0, 0, 1, 0);
        @(posedge clock);
        #1;
        chk("prereset_out_valid", bus.outValid, 1);
        #2;
        resetN = 1'b0;
        #1;
        chk("midrst_out_valid", bus.outValid, 0);
        chk("midrst_quire", $signed(bus.outQuire), 0);
        chk("midrst_inf", bus.outIsInf, 0);
        chk("midrst_ovf", bus.outOverflow, 0);
        chk("midrst_cnt", bus.outCount, 0);
        exp_q.delete();
        model_reset();
        @(posedge clock);
        #1;
        resetN = 1'b1;
        @(negedge clock);
        chk("postrst_in_ready", bus.inReady, 1);
        @(posedge clock);
        #1;

        // Randomized dot products against the reference model
        rnd_on = 1'b1;
        fork
            begin
                while (rnd_on) begin
                    @(posedge clock);
                    #1;
                    if (rnd_on) bus.outReady = ($urandom_range(0, 3) != 0);
                end
            end
        join_none
        for (int d = 0; d < 40; d++) begin
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) begin
                send($urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 1023),
                     ($urandom_range(0, 9) == 0), ($urandom_range(0, 15) == 0),
                     (k == len - 1), 1);
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clock);
                    #1;
                end
            end
        end
        rnd_on = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
